// File: rtl/lt24_frame_sequencer.sv
// LT24 8080-style write-bus owner: CPU pass-through plus a hardware frame sequencer (window setup, pixel stream).
// Optional macro LT24_UNDERRUN_CNT_EN adds underrun_cnt, counting pixel-source stall cycles within a frame.
module lt24_frame_sequencer #(
  parameter int WR_LOW_CYC  = 1,
  parameter int WR_HIGH_CYC = 1,
  parameter int MAX_X       = 239,
  parameter int MAX_Y       = 319
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [8:0]  win_x0,
  input  logic [8:0]  win_x1,
  input  logic [8:0]  win_y0,
  input  logic [8:0]  win_y1,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic        pix_req,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  input  logic        cpu_req,
  output logic        cpu_gnt,
  input  logic [15:0] cpu_d,
  input  logic        cpu_rs,
  input  logic        cpu_wr_n,
  input  logic        cpu_cs_n,
  output logic [15:0] lcd_d,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_cs_n,
  output logic        lcd_rd_n
`ifdef LT24_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU,
    S_CMD,
    S_STROBE,
    S_PIX_WAIT,
    S_DONE
  } state_t;

  localparam logic [8:0]  MAX_X9  = 9'(MAX_X);
  localparam logic [8:0]  MAX_Y9  = 9'(MAX_Y);
  localparam logic [15:0] LOW16   = 16'(WR_LOW_CYC);
  localparam logic [15:0] LAST16  = 16'(WR_LOW_CYC + WR_HIGH_CYC - 1);
  localparam logic [3:0]  LAST_K  = 4'd10;

  state_t      state, state_next;
  logic [3:0]  k;
  logic        in_pix;
  logic [15:0] stb_cnt;
  logic [16:0] pix_cnt;
  logic        err_q;
  logic [8:0]  x0, x1, y0, y1;
  logic [15:0] pix_reg;

  logic        win_bad;
  logic        accept;
  logic        err_set;
  logic        strobe_end;
  logic        pix_take;
  logic [16:0] w_span, h_span;

  // Window setup word k: column range, page range, then memory write.
  function automatic logic [15:0] cmd_word(input logic [3:0] idx,
                                           input logic [8:0] a0, input logic [8:0] a1,
                                           input logic [8:0] b0, input logic [8:0] b1);
    logic [15:0] w;
    case (idx)
      4'd0:    w = 16'h002A;
      4'd1:    w = {15'd0, a0[8]};
      4'd2:    w = {8'd0, a0[7:0]};
      4'd3:    w = {15'd0, a1[8]};
      4'd4:    w = {8'd0, a1[7:0]};
      4'd5:    w = 16'h002B;
      4'd6:    w = {15'd0, b0[8]};
      4'd7:    w = {8'd0, b0[7:0]};
      4'd8:    w = {15'd0, b1[8]};
      4'd9:    w = {8'd0, b1[7:0]};
      default: w = 16'h002C;
    endcase
    return w;
  endfunction

  function automatic logic cmd_rs(input logic [3:0] idx);
    return !(idx == 4'd0 || idx == 4'd5 || idx == 4'd10);
  endfunction

  assign win_bad = (win_x1 < win_x0) || (win_y1 < win_y0) || (win_x1 > MAX_X9) || (win_y1 > MAX_Y9);
  assign w_span  = {8'd0, win_x1} - {8'd0, win_x0} + 17'd1;
  assign h_span  = {8'd0, win_y1} - {8'd0, win_y0} + 17'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    err_set    = 1'b0;
    strobe_end = 1'b0;
    pix_take   = 1'b0;
    lcd_d      = 16'h0000;
    lcd_rs     = 1'b1;
    lcd_wr_n   = 1'b1;
    lcd_cs_n   = 1'b1;
    cpu_gnt    = 1'b0;
    frame_busy = 1'b0;
    frame_done = 1'b0;
    pix_req    = 1'b0;
    case (state)
      S_IDLE: begin
        // CPU wins a tie with frame_start; the frame request is simply dropped.
        if (cpu_req) begin
          state_next = S_CPU;
          cpu_gnt    = 1'b1;
          lcd_d      = cpu_d;
          lcd_rs     = cpu_rs;
          lcd_wr_n   = cpu_wr_n;
          lcd_cs_n   = cpu_cs_n;
        end else if (frame_start) begin
          if (win_bad) begin
            err_set = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = S_CMD;
          end
        end
      end
      S_CPU: begin
        if (cpu_req) begin
          cpu_gnt  = 1'b1;
          lcd_d    = cpu_d;
          lcd_rs   = cpu_rs;
          lcd_wr_n = cpu_wr_n;
          lcd_cs_n = cpu_cs_n;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_CMD: begin
        frame_busy = 1'b1;
        lcd_cs_n   = 1'b0;
        lcd_d      = cmd_word(k, x0, x1, y0, y1);
        lcd_rs     = cmd_rs(k);
        lcd_wr_n   = 1'b0;
        state_next = S_STROBE;
      end
      S_STROBE: begin
        frame_busy = 1'b1;
        lcd_cs_n   = 1'b0;
        lcd_d      = in_pix ? pix_reg : cmd_word(k, x0, x1, y0, y1);
        lcd_rs     = in_pix ? 1'b1 : cmd_rs(k);
        lcd_wr_n   = (stb_cnt >= LOW16);
        if (stb_cnt == LAST16) begin
          strobe_end = 1'b1;
          if (in_pix) state_next = (pix_cnt == 17'd1) ? S_DONE : S_PIX_WAIT;
          else        state_next = (k == LAST_K) ? S_PIX_WAIT : S_CMD;
        end
      end
      S_PIX_WAIT: begin
        frame_busy = 1'b1;
        lcd_cs_n   = 1'b0;
        lcd_d      = pix_reg;
        pix_req    = 1'b1;
        if (pix_valid) begin
          pix_take   = 1'b1;
          state_next = S_STROBE;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sequencing control: word index, phase, strobe timer and remaining-pixel count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= 4'd0;
      in_pix  <= 1'b0;
      stb_cnt <= 16'd0;
      pix_cnt <= 17'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_set;
      if (accept) begin
        k       <= 4'd0;
        in_pix  <= 1'b0;
        pix_cnt <= w_span * h_span;
      end
      if (state == S_CMD)       stb_cnt <= 16'd1;
      else if (pix_take)        stb_cnt <= 16'd0;
      else if (state == S_STROBE) stb_cnt <= stb_cnt + 16'd1;
      if (strobe_end) begin
        if (in_pix)            pix_cnt <= pix_cnt - 17'd1;
        else if (k == LAST_K)  in_pix  <= 1'b1;
        else                   k       <= k + 4'd1;
      end
    end
  end

  // Window and pixel holding registers carry data only, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      x0 <= win_x0;
      x1 <= win_x1;
      y0 <= win_y0;
      y1 <= win_y1;
    end
    if (pix_take) pix_reg <= pix_data;
  end

  assign frame_err = err_q;
  assign lcd_rd_n  = 1'b1;

`ifdef LT24_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         underrun_cnt <= 16'd0;
    else if (accept)                                 underrun_cnt <= 16'd0;
    else if (state == S_PIX_WAIT && !pix_valid && underrun_cnt != 16'hFFFF)
                                                     underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lt24_frame_sequencer.sv
// Directed and randomized bench for lt24_frame_sequencer against a transaction-level model of the bus.
module tb_lt24_frame_sequencer;
  localparam int L = 1;
  localparam int H = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [8:0]  win_x0 = '0, win_x1 = '0, win_y0 = '0, win_y1 = '0;
  logic        frame_busy, frame_done, frame_err, pix_req;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_gnt;
  logic [15:0] cpu_d = '0;
  logic        cpu_rs = 1'b1, cpu_wr_n = 1'b1, cpu_cs_n = 1'b1;
  logic [15:0] lcd_d;
  logic        lcd_rs, lcd_wr_n, lcd_cs_n, lcd_rd_n;
`ifdef LT24_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  lt24_frame_sequencer #(.WR_LOW_CYC(L), .WR_HIGH_CYC(H), .MAX_X(239), .MAX_Y(319)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .frame_busy(frame_busy), .frame_done(frame_done), .frame_err(frame_err),
    .pix_req(pix_req), .pix_valid(pix_valid), .pix_data(pix_data),
    .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .cpu_d(cpu_d), .cpu_rs(cpu_rs),
    .cpu_wr_n(cpu_wr_n), .cpu_cs_n(cpu_cs_n),
    .lcd_d(lcd_d), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_cs_n(lcd_cs_n), .lcd_rd_n(lcd_rd_n)
`ifdef LT24_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Bus monitor: one entry {rs, data} per sequencer-owned write strobe, plus a stability check.
  logic [16:0] cap_q[$];
  logic        prev_wr = 1'b1;
  logic [16:0] cur_word = '0;
  int          unstable = 0;
  always @(negedge clk) begin
    if (!cpu_gnt && lcd_wr_n === 1'b0) begin
      if (prev_wr) begin
        cap_q.push_back({lcd_rs, lcd_d});
        cur_word <= {lcd_rs, lcd_d};
      end else if ({lcd_rs, lcd_d} !== cur_word) begin
        unstable++;
      end
    end
    prev_wr <= lcd_wr_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [8:0] x0, input logic [8:0] x1,
                           input logic [8:0] y0, input logic [8:0] y1,
                           input int vprob, input int stall_first, input bit cpu_mid,
                           input bit randpix, input logic [15:0] fixpix, input bit noise,
                           output int stalls_o);
    logic [16:0] exp_q[$];
    logic [15:0] pix[$];
    int npix, idx, stalls, busy_cyc, cs_bad, gnt_bad, err_bad, first_left, bad_words, exp_cyc;
    bit done_seen, v;
    npix = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
    for (int i = 0; i < npix; i++) pix.push_back(randpix ? 16'($urandom) : fixpix);
    exp_q.push_back({1'b0, 16'h002A});
    exp_q.push_back({1'b1, 15'd0, x0[8]});
    exp_q.push_back({1'b1, 8'd0, x0[7:0]});
    exp_q.push_back({1'b1, 15'd0, x1[8]});
    exp_q.push_back({1'b1, 8'd0, x1[7:0]});
    exp_q.push_back({1'b0, 16'h002B});
    exp_q.push_back({1'b1, 15'd0, y0[8]});
    exp_q.push_back({1'b1, 8'd0, y0[7:0]});
    exp_q.push_back({1'b1, 15'd0, y1[8]});
    exp_q.push_back({1'b1, 8'd0, y1[7:0]});
    exp_q.push_back({1'b0, 16'h002C});
    foreach (pix[i]) exp_q.push_back({1'b1, pix[i]});

    cap_q.delete();
    unstable = 0;
    idx = 0; stalls = 0; busy_cyc = 0; cs_bad = 0; gnt_bad = 0; err_bad = 0;
    first_left = stall_first; done_seen = 0;
    @(negedge clk);
    frame_start = 1'b1;
    win_x0 = x0; win_x1 = x1; win_y0 = y0; win_y1 = y1;
    pix_valid = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    chk("latency_wr_n", lcd_wr_n, 1'b0);
    chk("latency_d", lcd_d, 16'h002A);
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) @(negedge clk);
      if (cpu_mid && cpu_gnt !== 1'b0) gnt_bad++;
      if (frame_err === 1'b1) err_bad++;
      if (frame_done === 1'b1) begin
        done_seen = 1;
        break;
      end
      if (frame_busy === 1'b1) begin
        busy_cyc++;
        if (lcd_cs_n !== 1'b0) cs_bad++;
      end
      if (cpu_mid && idx == 1) cpu_req = 1'b1;
      if (noise && c == 5) begin
        frame_start = 1'b1; win_x0 = 9'd10; win_x1 = 9'd5;
      end else if (noise && c == 6) begin
        frame_start = 1'b0; win_x0 = x0; win_x1 = x1;
      end
      if (pix_req === 1'b1) begin
        if (idx == 0 && first_left > 0) begin
          v = 0;
          first_left--;
        end else begin
          v = ($urandom_range(99) < vprob);
        end
        pix_valid = v;
        pix_data  = (v && idx < npix) ? pix[idx] : 16'($urandom);
        if (v) idx++;
        else stalls++;
      end else begin
        pix_valid = 1'($urandom_range(1));
        pix_data  = 16'($urandom);
      end
    end
    frame_start = 1'b0;
    chk("frame_done_seen", done_seen, 1'b1);
    chk("busy_at_done", frame_busy, 1'b0);
    chk("cs_at_done", lcd_cs_n, 1'b1);
    exp_cyc = 11 * (L + H) + npix * (1 + L + H) + stalls;
    chk("busy_cycles", busy_cyc, exp_cyc);
    pix_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse_width", frame_done, 1'b0);
    chk("cs_after_done", lcd_cs_n, 1'b1);
    if (cpu_mid) begin
      chk("gnt_held_during_frame", gnt_bad, 0);
      chk("gnt_after_done", cpu_gnt, 1'b1);
      cpu_req = 1'b0;
    end
    @(negedge clk);
    bad_words = 0;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) begin
        if (bad_words == 0)
          $display("word %0d differs: observed %0h expected %0h", i, cap_q[i], exp_q[i]);
        bad_words++;
      end
    chk("strobe_count", cap_q.size(), exp_q.size());
    chk("strobe_words", bad_words, 0);
    chk("strobe_stable", unstable, 0);
    chk("cs_low_in_frame", cs_bad, 0);
    chk("pixels_consumed", idx, npix);
    if (noise) chk("no_err_in_frame", err_bad, 0);
`ifdef LT24_UNDERRUN_CNT_EN
    chk("underrun_cnt", underrun_cnt, (stalls < 65535) ? stalls : 65535);
`endif
    stalls_o = stalls;
  endtask

  task automatic bad_window(input string tag, input logic [8:0] x0, input logic [8:0] x1,
                            input logic [8:0] y0, input logic [8:0] y1);
    cap_q.delete();
    @(negedge clk);
    frame_start = 1'b1;
    win_x0 = x0; win_x1 = x1; win_y0 = y0; win_y1 = y1;
    @(negedge clk);
    frame_start = 1'b0;
    chk({tag, "_err"}, frame_err, 1'b1);
    chk({tag, "_busy"}, frame_busy, 1'b0);
    @(negedge clk);
    chk({tag, "_err_pulse"}, frame_err, 1'b0);
    repeat (3) @(negedge clk);
    chk({tag, "_no_strobe"}, cap_q.size(), 0);
  endtask

  initial begin
    int st, quiet_bad;
    logic [8:0] rx0, rx1, ry0, ry1;
    logic [15:0] d;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_lcd_d", lcd_d, 16'h0000);
    chk("rst_lcd_rs", lcd_rs, 1'b1);
    chk("rst_lcd_wr_n", lcd_wr_n, 1'b1);
    chk("rst_lcd_cs_n", lcd_cs_n, 1'b1);
    chk("rst_lcd_rd_n", lcd_rd_n, 1'b1);
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_busy", frame_busy, 1'b0);
    chk("rst_pix_req", pix_req, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    rst = 1'b0;
`ifdef LT24_UNDERRUN_CNT_EN
    chk("rst_underrun", underrun_cnt, 0);
`endif
    @(negedge clk);

    // Full 2x2 frame, constant red pixels, source always ready
    run_frame(9'd0, 9'd1, 9'd0, 9'd1, 100, 0, 0, 0, 16'hF800, 0, st);

    // Rejected windows
    bad_window("x_reversed", 9'd10, 9'd5, 9'd0, 9'd0);
    bad_window("y_reversed", 9'd0, 9'd0, 9'd5, 9'd4);
    bad_window("x_too_big", 9'd0, 9'd240, 9'd0, 9'd0);
    bad_window("y_too_big", 9'd0, 9'd0, 9'd0, 9'd320);

    // CPU request and frame_start together: CPU wins immediately
    @(negedge clk);
    d = 16'($urandom);
    cpu_req = 1'b1; frame_start = 1'b1;
    win_x0 = 0; win_x1 = 1; win_y0 = 0; win_y1 = 1;
    cpu_d = d; cpu_rs = 1'b0; cpu_cs_n = 1'b0; cpu_wr_n = 1'b1;
    #1;
    chk("sim_gnt", cpu_gnt, 1'b1);
    chk("sim_pass_d", lcd_d, d);
    chk("sim_pass_rs", lcd_rs, 1'b0);
    chk("sim_pass_cs", lcd_cs_n, 1'b0);
    cpu_wr_n = 1'b0;
    #1;
    chk("sim_pass_wr_low", lcd_wr_n, 1'b0);
    @(negedge clk);
    frame_start = 1'b0;
    chk("sim_gnt_held", cpu_gnt, 1'b1);
    chk("sim_frame_dropped", frame_busy, 1'b0);
    cpu_wr_n = 1'b1;
    #1;
    chk("sim_pass_wr_high", lcd_wr_n, 1'b1);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("sim_gnt_release", cpu_gnt, 1'b0);
    chk("sim_cs_release", lcd_cs_n, 1'b1);
    cpu_cs_n = 1'b1; cpu_rs = 1'b1;
    @(negedge clk);
    chk("sim_still_idle", frame_busy, 1'b0);

    // CPU request raised during pixel 2 of a 4-pixel frame
    run_frame(9'd0, 9'd1, 9'd0, 9'd1, 100, 0, 1, 1, 16'h0000, 0, st);

    // Source stalls 5 cycles before the first pixel
    run_frame(9'd3, 9'd4, 9'd7, 9'd7, 100, 5, 0, 1, 16'h0000, 0, st);
    chk("stall_cycles", st, 5);

    // Asynchronous reset while command word 7 is being strobed
    cap_q.delete();
    @(negedge clk);
    frame_start = 1'b1; pix_valid = 1'b1;
    win_x0 = 0; win_x1 = 3; win_y0 = 0; win_y1 = 3;
    @(negedge clk);
    frame_start = 1'b0;
    for (int c = 0; c < 100 && cap_q.size() < 8; c++) begin
      @(negedge clk);
      #1;
    end
    chk("k7_reached", cap_q.size(), 8);
    chk("k7_low", lcd_wr_n, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_cs", lcd_cs_n, 1'b1);
    chk("arst_wr", lcd_wr_n, 1'b1);
    chk("arst_busy", frame_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    quiet_bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || frame_busy !== 1'b0) quiet_bad++;
    end
    chk("no_done_after_reset", quiet_bad, 0);
    pix_valid = 1'b0;
    run_frame(9'd0, 9'd1, 9'd0, 9'd1, 100, 0, 0, 1, 16'h0000, 0, st);

    // Corner pixel at the largest legal coordinates
    run_frame(9'd239, 9'd239, 9'd319, 9'd319, 100, 0, 0, 1, 16'h0000, 0, st);

    // Random small windows, random source readiness, ignored frame_start mid-frame
    for (int n = 0; n < 6; n++) begin
      rx0 = 9'($urandom_range(0, 239));
      rx1 = 9'((int'(rx0) + $urandom_range(0, 3) > 239) ? 239 : int'(rx0) + $urandom_range(0, 3));
      ry0 = 9'($urandom_range(0, 319));
      ry1 = 9'((int'(ry0) + $urandom_range(0, 3) > 319) ? 319 : int'(ry0) + $urandom_range(0, 3));
      run_frame(rx0, rx1, ry0, ry1, 60, 0, 0, 1, 16'h0000, 1, st);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lt24_frame_sequencer.md
Name: lt24_frame_sequencer

Overview:
Owns the LT24 8080-style parallel write bus and shares it between two requesters:
- the CPU, through a pass-through, and
- a hardware pixel source, through a valid/request stream.

For a hardware frame it issues the window setup sequence (0x2A column, 0x2B page, 0x2C memory write). It then streams exactly W×H pixels with programmable write-strobe timing. Ownership changes only at frame boundaries, so a CPU access can never corrupt a frame in flight.

Parameters:
WR_LOW_CYC, 1, cycles lcd_wr_n held low per word (≥1)
WR_HIGH_CYC, 1, cycles lcd_wr_n held high per word (≥1)
MAX_X, 239, largest legal column index
MAX_Y, 319, largest legal row index

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
frame_start  in  1  one-cycle pulse, request a hardware frame
win_x0  in  9  first column, sampled with frame_start
win_x1  in  9  last column, sampled with frame_start
win_y0  in  9  first row, sampled with frame_start
win_y1  in  9  last row, sampled with frame_start
frame_busy  out  1  hardware frame in progress
frame_done  out  1  one-cycle pulse, frame completed
frame_err  out  1  one-cycle pulse, window rejected
pix_req  out  1  sequencer ready for next pixel
pix_valid  in  1  pixel source has data
pix_data  in  16  RGB565 pixel
cpu_req  in  1  CPU requests bus ownership (level)
cpu_gnt  out  1  CPU owns bus
cpu_d  in  16  CPU data bus
cpu_rs  in  1  CPU register select
cpu_wr_n  in  1  CPU write strobe
cpu_cs_n  in  1  CPU chip select
lcd_d  out  16  panel data
lcd_rs  out  1  panel register select (0 = command)
lcd_wr_n  out  1  panel write strobe
lcd_cs_n  out  1  panel chip select
lcd_rd_n  out  1  panel read strobe, constant 1

Behaviour:
- Reset values (asynchronous): state IDLE; lcd_d=0, lcd_rs=1, lcd_wr_n=1, lcd_cs_n=1, lcd_rd_n=1; cpu_gnt=0, frame_busy=0, pix_req=0; frame_done=0, frame_err=0.
- Reset mid-frame: the frame is abandoned and no frame_done is issued. The panel keeps the partial image.
- States:
  - IDLE → CPU: when cpu_req=1. CPU has priority over a simultaneous frame_start; that frame_start is dropped.
  - IDLE → CMD: on frame_start when the window is valid. Window registers are latched, the command index is cleared, frame_busy=1.
  - IDLE → IDLE with frame_err: on frame_start when x1<x0, y1<y0, x1>MAX_X or y1>MAX_Y.
  - CPU: cpu_gnt=1. lcd_d/rs/wr_n/cs_n follow cpu_* combinationally. Return to IDLE on the first cycle cpu_req=0; cpu_gnt drops in that cycle.
  - CMD: drives command word k (k = 0..10) and strobes it.
    - Word list: 0x2A, x0[8], x0[7:0], x1[8], x1[7:0], 0x2B, y0[8], y0[7:0], y1[8], y1[7:0], 0x2C. Data words are zero-extended to 16 bits.
    - lcd_rs=0 for k ∈ {0, 5, 10}, 1 otherwise.
    - After k=10 completes → PIX_WAIT.
  - PIX_WAIT: pix_req=1. On pix_valid=1, pix_data is latched, pix_req drops, and the state moves to STROBE with lcd_rs=1.
  - STROBE: lcd_wr_n=0 for WR_LOW_CYC cycles, then 1 for WR_HIGH_CYC cycles. Afterwards:
    - in command phase, return to CMD;
    - in pixel phase, decrement the 17-bit pixel counter (preloaded with (x1-x0+1)*(y1-y0+1)); go to DONE if it reaches 0, else PIX_WAIT.
  - DONE: one cycle. lcd_cs_n=1, frame_done=1, frame_busy=0 → IDLE.
- lcd_cs_n is held low from the first CMD cycle through the last strobe. Data and rs are stable for the whole strobe window.
- Latency: frame_start sampled at cycle N → lcd_wr_n low with lcd_d=0x002A at cycle N+1.
- Cost per word: WR_LOW_CYC+WR_HIGH_CYC cycles per command; one extra cycle per pixel for PIX_WAIT with pix_valid tied high.
- frame_start during frame_busy or CPU ownership is ignored (no error).
- cpu_req rising during a frame is granted only after DONE → IDLE.
- Width rules: window fields are 9-bit unsigned; the pixel count product is 17-bit and cannot overflow for legal windows.

Optional Feature:
LT24_UNDERRUN_CNT_EN
- Defined:
  - Adds output underrun_cnt[15:0]: counts cycles in PIX_WAIT with pix_valid=0 during a frame.
  - Saturates at 0xFFFF, clears on frame_start acceptance, resets to 0.
  - Holds its value after DONE.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Full 2×2 frame: rst, then frame_start with x0=0, x1=1, y0=0, y1=1, pix_valid=1, pix_data=0xF800, timing 1/1.
  Expect 11 command strobes with lcd_d = 2A,0,0,0,1,2B,0,0,0,1,2C and rs = 0,1,1,1,1,0,1,1,1,1,0. Then 4 pixel strobes at 0xF800, frame_done 34 cycles after frame_start, lcd_cs_n=1 after.
- Invalid window: frame_start with x0=10, x1=5 → frame_err pulse, frame_busy stays 0, no lcd_wr_n activity.
- Simultaneous requests: cpu_req=1 and frame_start in the same IDLE cycle → cpu_gnt=1, frame dropped. A cpu_wr_n toggle appears on lcd_wr_n same-cycle.
- CPU request mid-frame: cpu_req rises during pixel 2 of a 4-pixel frame. cpu_gnt stays 0 until after frame_done, then asserts the next cycle.
- Stalled source: pix_valid low for 5 cycles before pixel 1. Expect pix_req held, no strobe, lcd_cs_n stays 0. With LT24_UNDERRUN_CNT_EN, underrun_cnt=5.
- Reset mid-frame: rst asserted during command k=7 → lcd_cs_n=1 and lcd_wr_n=1 immediately (asynchronous), no frame_done. A following frame_start completes normally.
